iniciador_entrada_salida: RTL and testbench

INICIADOR_ENTRADA_SALIDA -- requirements
Module: iniciador_entrada_salida

---
 rtl/iniciador_entrada_salida.sv | 151 +++++++++++++++
 tb/tb_iniciador_entrada_salida.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iniciador_entrada_salida.sv
// I/O bus initiator: turns a single core request into a timed I/O bus read or write.
// Optional macro IO_ADDR_CHECK_EN rejects addresses above 4 with a one-cycle error pulse.
module iniciador_entrada_salida #(
    parameter int CICLOS_ESPERA = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       peticion,
    input  logic       escribir,
    input  logic [6:0] direccion,
    input  logic [7:0] datoEscribir,
    output logic [7:0] datoLeido,
    output logic       ocupado,
    output logic       hecho,
    output logic       error,
    output logic       activarEntradaSalida,
    output logic       escribirEntradaSalida,
    output logic [6:0] direccionEntradaSalida,
    output logic [7:0] entradaEntradaSalida,
    input  logic [7:0] salidaEntradaSalida
);

    typedef enum logic [2:0] {REPOSO, PREPARAR, ACCESO, CAPTURA, FIN} estado_t;

    localparam logic [3:0] ULTIMO = 4'(CICLOS_ESPERA - 1);

    estado_t    estado_reg, estado_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       esc_lat_reg, esc_lat_next;
    logic [6:0] dir_lat_reg, dir_lat_next;
    logic [7:0] dato_lat_reg, dato_lat_next;

    logic [7:0] dato_leido_reg, dato_leido_next;
    logic       ocupado_reg, ocupado_next;
    logic       hecho_reg, hecho_next;
    logic       error_reg, error_next;
    logic       activar_reg, activar_next;
    logic       esc_es_reg, esc_es_next;
    logic [6:0] dir_es_reg, dir_es_next;
    logic [7:0] ent_es_reg, ent_es_next;

    logic addr_err;

`ifdef IO_ADDR_CHECK_EN
    assign addr_err = (direccion > 7'd4);
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        estado_next   = estado_reg;
        cnt_next      = cnt_reg;
        esc_lat_next  = esc_lat_reg;
        dir_lat_next  = dir_lat_reg;
        dato_lat_next = dato_lat_reg;
        dato_leido_next = dato_leido_reg;
        error_next    = 1'b0;

        case (estado_reg)
            REPOSO: begin
                if (peticion) begin
                    esc_lat_next  = escribir;
                    dir_lat_next  = direccion;
                    dato_lat_next = datoEscribir;
                    if (addr_err) begin
                        estado_next = FIN;
                        error_next  = 1'b1;
                    end else begin
                        estado_next = PREPARAR;
                    end
                end
            end
            PREPARAR: begin
                estado_next = ACCESO;
                cnt_next    = 4'd0;
            end
            ACCESO: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == ULTIMO)
                    estado_next = CAPTURA;
            end
            CAPTURA: begin
                if (!esc_lat_reg)
                    dato_leido_next = salidaEntradaSalida;
                estado_next = FIN;
            end
            FIN: begin
                estado_next = REPOSO;
            end
            default: begin
                estado_next = REPOSO;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ocupado_next = (estado_next != REPOSO);
        hecho_next   = (estado_next == FIN);
        activar_next = (estado_next == ACCESO) || (estado_next == CAPTURA);
        if ((estado_next == PREPARAR) || (estado_next == ACCESO) || (estado_next == CAPTURA)) begin
            esc_es_next = esc_lat_next;
            dir_es_next = dir_lat_next;
            ent_es_next = dato_lat_next;
        end else begin
            esc_es_next = 1'b0;
            dir_es_next = 7'd0;
            ent_es_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_reg     <= REPOSO;
            cnt_reg        <= 4'd0;
            esc_lat_reg    <= 1'b0;
            dir_lat_reg    <= 7'd0;
            dato_lat_reg   <= 8'd0;
            dato_leido_reg <= 8'd0;
            ocupado_reg    <= 1'b0;
            hecho_reg      <= 1'b0;
            error_reg      <= 1'b0;
            activar_reg    <= 1'b0;
            esc_es_reg     <= 1'b0;
            dir_es_reg     <= 7'd0;
            ent_es_reg     <= 8'd0;
        end else begin
            estado_reg     <= estado_next;
            cnt_reg        <= cnt_next;
            esc_lat_reg    <= esc_lat_next;
            dir_lat_reg    <= dir_lat_next;
            dato_lat_reg   <= dato_lat_next;
            dato_leido_reg <= dato_leido_next;
            ocupado_reg    <= ocupado_next;
            hecho_reg      <= hecho_next;
            error_reg      <= error_next;
            activar_reg    <= activar_next;
            esc_es_reg     <= esc_es_next;
            dir_es_reg     <= dir_es_next;
            ent_es_reg     <= ent_es_next;
        end
    end

    assign datoLeido              = dato_leido_reg;
    assign ocupado                = ocupado_reg;
    assign hecho                  = hecho_reg;
    assign error                  = error_reg;
    assign activarEntradaSalida   = activar_reg;
    assign escribirEntradaSalida  = esc_es_reg;
    assign direccionEntradaSalida = dir_es_reg;
    assign entradaEntradaSalida   = ent_es_reg;

endmodule

// File: tb/tb_iniciador_entrada_salida.sv
// Bench for iniciador_entrada_salida: two instances (wait 1 and wait 3) against a phase-based model,
// plus literal timing checks. Honours IO_ADDR_CHECK_EN the same way as the design.
module tb_iniciador_entrada_salida;

`ifdef IO_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       peticion;
    logic       escribir;
    logic [6:0] direccion;
    logic [7:0] datoEscribir;
    logic [7:0] salida;

    logic [7:0] dl      [2];
    logic       ocu     [2];
    logic       hec     [2];
    logic       err     [2];
    logic       act     [2];
    logic       esc_es  [2];
    logic [6:0] dir_es  [2];
    logic [7:0] ent_es  [2];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 1'b0;
    int  cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act_v, exp_v);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int C = (gi == 0) ? 1 : 3;

        iniciador_entrada_salida #(.CICLOS_ESPERA(C)) dut (
            .clk(clk), .reset(reset), .peticion(peticion), .escribir(escribir),
            .direccion(direccion), .datoEscribir(datoEscribir),
            .datoLeido(dl[gi]), .ocupado(ocu[gi]), .hecho(hec[gi]), .error(err[gi]),
            .activarEntradaSalida(act[gi]), .escribirEntradaSalida(esc_es[gi]),
            .direccionEntradaSalida(dir_es[gi]), .entradaEntradaSalida(ent_es[gi]),
            .salidaEntradaSalida(salida)
        );

        // Model: k = cycles elapsed since the request was accepted.
        bit         busy = 0, lw = 0, et = 0;
        int         k = 0;
        logic [6:0] la = '0;
        logic [7:0] ld = '0, edat = '0;

        always @(posedge clk) begin
            if (reset) begin
                busy = 0; k = 0; lw = 0; la = '0; ld = '0; edat = '0; et = 0;
            end else if (!busy) begin
                if (peticion) begin
                    busy = 1; k = 1; lw = escribir; la = direccion; ld = datoEscribir;
                    et = ADDR_CHK && (direccion > 7'd4);
                end
            end else begin
                if (!et && k == 2 + C && !lw) edat = salida;
                if (k == (et ? 1 : 3 + C)) busy = 0;
                else k++;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                bit on_bus;
                on_bus = busy && !et && (k <= 2 + C);
                chk($sformatf("m%0d.ocupado", gi),  8'(ocu[gi]), 8'(busy));
                chk($sformatf("m%0d.hecho", gi),    8'(hec[gi]), 8'(busy && k == (et ? 1 : 3 + C)));
                chk($sformatf("m%0d.error", gi),    8'(err[gi]), 8'(busy && et));
                chk($sformatf("m%0d.activar", gi),  8'(act[gi]), 8'(on_bus && k >= 2));
                chk($sformatf("m%0d.escES", gi),    8'(esc_es[gi]), 8'(on_bus && lw));
                chk($sformatf("m%0d.dirES", gi),    8'(dir_es[gi]), on_bus ? 8'(la) : 8'h00);
                chk($sformatf("m%0d.entES", gi),    ent_es[gi], on_bus ? ld : 8'h00);
                chk($sformatf("m%0d.datoLeido", gi), dl[gi], edat);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise peticion for exactly one cycle (cycle 0); returns in cycle 1.
    task automatic req(input logic w, input logic [6:0] a, input logic [7:0] d);
        peticion = 1'b1; escribir = w; direccion = a; datoEscribir = d;
        step(1);
        peticion = 1'b0;
    endtask

    initial begin
        reset = 1'b1; peticion = 1'b0; escribir = 1'b0;
        direccion = '0; datoEscribir = '0; salida = 8'h00;
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("reset.ocupado", 8'(ocu[0]), 8'h00);
        chk("reset.datoLeido", dl[1], 8'h00);
        reset = 1'b0;
        step(2);

        // Write dir 2 data A5, wait 1 cycle
        req(1'b1, 7'd2, 8'hA5);                       // now cycle 1
        chk("w.c1.ocupado", 8'(ocu[0]), 8'h01);
        chk("w.c1.activar", 8'(act[0]), 8'h00);
        step(1);                                      // cycle 2
        chk("w.c2.activar", 8'(act[0]), 8'h01);
        chk("w.c2.escES", 8'(esc_es[0]), 8'h01);
        chk("w.c2.dirES", 8'(dir_es[0]), 8'h02);
        chk("w.c2.entES", ent_es[0], 8'hA5);
        step(1);                                      // cycle 3
        chk("w.c3.activar", 8'(act[0]), 8'h01);
        chk("w.c3.entES", ent_es[0], 8'hA5);
        step(1);                                      // cycle 4
        chk("w.c4.hecho", 8'(hec[0]), 8'h01);
        chk("w.c4.activar", 8'(act[0]), 8'h00);
        chk("w.c4.dirES", 8'(dir_es[0]), 8'h00);
        chk("w.c4.datoLeido", dl[0], 8'h00);
        step(6);

        // Read dir 3, bus returns 3C
        salida = 8'h3C;
        req(1'b0, 7'd3, 8'h55);
        step(1);                                      // cycle 2
        chk("r.c2.escES", 8'(esc_es[0]), 8'h00);
        chk("r.c2.activar", 8'(act[0]), 8'h01);
        step(2);                                      // cycle 4
        chk("r.c4.hecho", 8'(hec[0]), 8'h01);
        chk("r.c4.datoLeido", dl[0], 8'h3C);
        step(6);

        // Wait 3: read, second request at cycle 2 ignored
        salida = 8'h71;
        req(1'b0, 7'd1, 8'h00);                       // cycle 1
        chk("w3.c1.ocupado", 8'(ocu[1]), 8'h01);
        peticion = 1'b1; escribir = 1'b1; direccion = 7'd4;
        step(1);                                      // cycle 2
        peticion = 1'b0;
        chk("w3.c2.activar", 8'(act[1]), 8'h01);
        step(3);                                      // cycle 5
        chk("w3.c5.activar", 8'(act[1]), 8'h01);
        chk("w3.c5.hecho", 8'(hec[1]), 8'h00);
        step(1);                                      // cycle 6
        chk("w3.c6.hecho", 8'(hec[1]), 8'h01);
        chk("w3.c6.activar", 8'(act[1]), 8'h00);
        chk("w3.c6.ocupado", 8'(ocu[1]), 8'h01);
        chk("w3.c6.datoLeido", dl[1], 8'h71);
        step(1);                                      // cycle 7
        chk("w3.c7.ocupado", 8'(ocu[1]), 8'h00);
        step(5);

        // Reset during second ACCESO cycle of the wait-3 instance
        req(1'b1, 7'd3, 8'hC3);                       // cycle 1
        step(2);                                      // cycle 3
        reset = 1'b1;
        step(1);                                      // cycle 4
        reset = 1'b0;
        chk("rst.ocupado", 8'(ocu[1]), 8'h00);
        chk("rst.activar", 8'(act[1]), 8'h00);
        chk("rst.hecho", 8'(hec[1]), 8'h00);
        chk("rst.entES", ent_es[1], 8'h00);
        chk("rst.datoLeido", dl[1], 8'h00);
        step(6);

        // Reset and peticion in the same cycle
        reset = 1'b1;
        req(1'b0, 7'd1, 8'h00);
        reset = 1'b0;
        chk("rstpri.ocupado", 8'(ocu[0]), 8'h00);
        step(3);

        // Address 7 read
        salida = 8'h9E;
        req(1'b0, 7'd7, 8'h00);                       // cycle 1
        chk("a7.c1.hecho", 8'(hec[0]), 8'(ADDR_CHK));
        chk("a7.c1.error", 8'(err[0]), 8'(ADDR_CHK));
        step(3);                                      // cycle 4
        chk("a7.c4.hecho", 8'(hec[0]), 8'(!ADDR_CHK));
        chk("a7.c4.datoLeido", dl[0], ADDR_CHK ? 8'h00 : 8'h9E);
        step(6);

        // peticion held high: back-to-back, spacing 4+C
        salida = 8'h42;
        peticion = 1'b1; escribir = 1'b0; direccion = 7'd1;
        step(4);                                      // cycle 4
        chk("b2b.c4.hecho", 8'(hec[0]), 8'h01);
        step(5);                                      // cycle 9
        chk("b2b.c9.hecho", 8'(hec[0]), 8'h01);
        step(20);
        peticion = 1'b0;
        step(10);

        // Compact table of mixed transactions, checked by the model
        for (int i = 0; i < 6; i++) begin
            salida = 8'(8'h10 * i + 3);
            req(1'(i % 2), 7'(i + 1), 8'(8'hF0 - i));
            step(9);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
